// File: rtl/rs_dispatcher.sv
// One-entry issue buffer between decoder and reservation station: resolves operands, snoops result buses.
// Optional RS_DISPATCH_STATS_EN adds stat_dispatched / stat_stall counters.
module rs_dispatcher #(
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned OP_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [ROB_ID_W-1:0] in_dest,
  input  logic [ROB_ID_W-1:0] rj_tag,
  input  logic [ROB_ID_W-1:0] rk_tag,
  input  logic [XLEN-1:0]     rj_val,
  input  logic [XLEN-1:0]     rk_val,
  input  logic                rj_rob_rdy,
  input  logic                rk_rob_rdy,
  input  logic [XLEN-1:0]     rj_rob_val,
  input  logic [XLEN-1:0]     rk_rob_val,
  input  logic [ROB_ID_W-1:0] dest_from_lsb_bus,
  input  logic [XLEN-1:0]     value_from_lsb_bus,
  input  logic [ROB_ID_W-1:0] dest_from_rss_bus,
  input  logic [XLEN-1:0]     value_from_rss_bus,
  input  logic                reset_from_rob_bus,
  input  logic                is_rs_station_full,
  output logic [ROB_ID_W-1:0] dest_to_rs,
  output logic [OP_W-1:0]     op_to_rs,
  output logic [XLEN-1:0]     imm_to_rs,
  output logic [XLEN-1:0]     pc_to_rs,
  output logic [ROB_ID_W-1:0] qj_to_rs,
  output logic [ROB_ID_W-1:0] qk_to_rs,
  output logic [XLEN-1:0]     vj_to_rs,
  output logic [XLEN-1:0]     vk_to_rs
`ifdef RS_DISPATCH_STATS_EN
  ,
  output logic [31:0]         stat_dispatched,
  output logic [31:0]         stat_stall
`endif
);

  localparam int unsigned QV_W = ROB_ID_W + XLEN;

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t                state_q;
  logic [OP_W-1:0]       op_q;
  logic [XLEN-1:0]       imm_q, pc_q;
  logic [ROB_ID_W-1:0]   dest_q, qj_q, qk_q;
  logic [XLEN-1:0]       vj_q, vk_q;

  logic                  fire, accept;
  logic [QV_W-1:0]       res_j, res_k, snp_j, snp_k;

  // Accept-time operand resolution: regfile, then buses (lsb first), then ROB, else wait on tag.
  function automatic logic [QV_W-1:0] resolve(input logic [ROB_ID_W-1:0] tag,
                                               input logic [XLEN-1:0]     rf_val,
                                               input logic                rob_rdy,
                                               input logic [XLEN-1:0]     rob_val);
    if (tag == '0)                    return {ROB_ID_W'(0), rf_val};
    else if (tag == dest_from_lsb_bus) return {ROB_ID_W'(0), value_from_lsb_bus};
    else if (tag == dest_from_rss_bus) return {ROB_ID_W'(0), value_from_rss_bus};
    else if (rob_rdy)                 return {ROB_ID_W'(0), rob_val};
    else                              return {tag, XLEN'(0)};
  endfunction

  // Capture a pending operand from whichever bus broadcasts its tag this cycle.
  function automatic logic [QV_W-1:0] snoop(input logic [ROB_ID_W-1:0] q,
                                             input logic [XLEN-1:0]     v);
    if (q != '0 && q == dest_from_lsb_bus)      return {ROB_ID_W'(0), value_from_lsb_bus};
    else if (q != '0 && q == dest_from_rss_bus) return {ROB_ID_W'(0), value_from_rss_bus};
    else                                        return {q, v};
  endfunction

  assign fire     = rdy & (state_q == HOLD) & ~is_rs_station_full & ~reset_from_rob_bus;
  assign in_ready = rdy & ~reset_from_rob_bus & ((state_q == EMPTY) | fire);
  assign accept   = in_valid & in_ready;

  assign res_j = resolve(rj_tag, rj_val, rj_rob_rdy, rj_rob_val);
  assign res_k = resolve(rk_tag, rk_val, rk_rob_rdy, rk_rob_val);
  assign snp_j = snoop(qj_q, vj_q);
  assign snp_k = snoop(qk_q, vk_q);

  // Issue outputs exist only in the fire cycle, with same-cycle broadcasts forwarded.
  always_comb begin
    dest_to_rs = '0;
    op_to_rs   = '0;
    imm_to_rs  = '0;
    pc_to_rs   = '0;
    qj_to_rs   = '0;
    vj_to_rs   = '0;
    qk_to_rs   = '0;
    vk_to_rs   = '0;
    if (fire) begin
      dest_to_rs           = dest_q;
      op_to_rs             = op_q;
      imm_to_rs            = imm_q;
      pc_to_rs             = pc_q;
      {qj_to_rs, vj_to_rs} = snp_j;
      {qk_to_rs, vk_to_rs} = snp_k;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      op_q    <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      dest_q  <= '0;
      qj_q    <= '0;
      vj_q    <= '0;
      qk_q    <= '0;
      vk_q    <= '0;
    end else if (rdy) begin
      if (reset_from_rob_bus) begin
        state_q <= EMPTY;
        op_q    <= '0;
        imm_q   <= '0;
        pc_q    <= '0;
        dest_q  <= '0;
        qj_q    <= '0;
        vj_q    <= '0;
        qk_q    <= '0;
        vk_q    <= '0;
      end else if (accept) begin
        state_q      <= HOLD;
        op_q         <= in_op;
        imm_q        <= in_imm;
        pc_q         <= in_pc;
        dest_q       <= in_dest;
        {qj_q, vj_q} <= res_j;
        {qk_q, vk_q} <= res_k;
      end else if (fire) begin
        state_q <= EMPTY;
      end else if (state_q == HOLD) begin
        {qj_q, vj_q} <= snp_j;
        {qk_q, vk_q} <= snp_k;
      end
    end
  end

`ifdef RS_DISPATCH_STATS_EN
  logic [31:0] stat_disp_q, stat_stall_q;

  // Statistics survive misprediction flushes; only the async reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_disp_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (fire) stat_disp_q <= stat_disp_q + 32'(1);
      if (rdy && state_q == HOLD && is_rs_station_full) stat_stall_q <= stat_stall_q + 32'(1);
    end
  end

  assign stat_dispatched = stat_disp_q;
  assign stat_stall      = stat_stall_q;
`endif

endmodule

// File: tb/tb_rs_dispatcher.sv
// Self-checking bench for rs_dispatcher: vector table plus directed multi-cycle sequences.
module tb_rs_dispatcher;

  logic        clk = 1'b0;
  logic        rst, rdy, in_valid, in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_imm, in_pc;
  logic [3:0]  in_dest, rj_tag, rk_tag;
  logic [31:0] rj_val, rk_val, rj_rob_val, rk_rob_val;
  logic        rj_rob_rdy, rk_rob_rdy;
  logic [3:0]  dest_from_lsb_bus, dest_from_rss_bus;
  logic [31:0] value_from_lsb_bus, value_from_rss_bus;
  logic        reset_from_rob_bus, is_rs_station_full;
  logic [3:0]  dest_to_rs, qj_to_rs, qk_to_rs;
  logic [5:0]  op_to_rs;
  logic [31:0] imm_to_rs, pc_to_rs, vj_to_rs, vk_to_rs;
`ifdef RS_DISPATCH_STATS_EN
  logic [31:0] stat_dispatched, stat_stall;
`endif

  rs_dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc), .in_dest(in_dest),
    .rj_tag(rj_tag), .rk_tag(rk_tag), .rj_val(rj_val), .rk_val(rk_val),
    .rj_rob_rdy(rj_rob_rdy), .rk_rob_rdy(rk_rob_rdy),
    .rj_rob_val(rj_rob_val), .rk_rob_val(rk_rob_val),
    .dest_from_lsb_bus(dest_from_lsb_bus), .value_from_lsb_bus(value_from_lsb_bus),
    .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
    .reset_from_rob_bus(reset_from_rob_bus), .is_rs_station_full(is_rs_station_full),
    .dest_to_rs(dest_to_rs), .op_to_rs(op_to_rs), .imm_to_rs(imm_to_rs), .pc_to_rs(pc_to_rs),
    .qj_to_rs(qj_to_rs), .qk_to_rs(qk_to_rs), .vj_to_rs(vj_to_rs), .vk_to_rs(vk_to_rs)
`ifdef RS_DISPATCH_STATS_EN
    , .stat_dispatched(stat_dispatched), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  dest;
    logic [3:0]  rj_tag;  logic [31:0] rj_val;  logic rj_rr;  logic [31:0] rj_rv;
    logic [3:0]  rk_tag;  logic [31:0] rk_val;  logic rk_rr;  logic [31:0] rk_rv;
    logic [3:0]  lsb_d;   logic [31:0] lsb_v;
    logic [3:0]  rss_d;   logic [31:0] rss_v;
    logic [3:0]  eqj;     logic [31:0] evj;
    logic [3:0]  eqk;     logic [31:0] evk;
  } vec_t;

  typedef struct {
    logic [3:0]  dest;  logic [5:0]  op;
    logic [31:0] imm;   logic [31:0] pc;
    logic [3:0]  qj;    logic [31:0] vj;
    logic [3:0]  qk;    logic [31:0] vk;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] d, input logic [5:0] op, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [3:0] qj, input logic [31:0] vj,
                          input logic [3:0] qk, input logic [31:0] vk);
    exp_t e;
    e.dest = d; e.op = op; e.imm = imm; e.pc = pc;
    e.qj = qj; e.vj = vj; e.qk = qk; e.vk = vk;
    sb.push_back(e);
  endtask

  // Scoreboard: every nonzero dest_to_rs must match the oldest outstanding accepted instruction.
  always @(negedge clk) begin
    if (rst === 1'b1 && dest_to_rs != 4'd0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dispatch actual=%0h required=none", dest_to_rs);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("disp_dest", 64'(dest_to_rs), 64'(e.dest));
        chk("disp_op",   64'(op_to_rs),   64'(e.op));
        chk("disp_imm",  64'(imm_to_rs),  64'(e.imm));
        chk("disp_pc",   64'(pc_to_rs),   64'(e.pc));
        chk("disp_qj",   64'(qj_to_rs),   64'(e.qj));
        chk("disp_vj",   64'(vj_to_rs),   64'(e.vj));
        chk("disp_qk",   64'(qk_to_rs),   64'(e.qk));
        chk("disp_vk",   64'(vk_to_rs),   64'(e.vk));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic clear_in();
    in_valid = 0; in_op = '0; in_imm = '0; in_pc = '0; in_dest = '0;
    rj_tag = '0; rk_tag = '0; rj_val = '0; rk_val = '0;
    rj_rob_rdy = 0; rk_rob_rdy = 0; rj_rob_val = '0; rk_rob_val = '0;
    dest_from_lsb_bus = '0; value_from_lsb_bus = '0;
    dest_from_rss_bus = '0; value_from_rss_bus = '0;
  endtask

  task automatic offer(input logic [5:0] op, input logic [3:0] d, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] jt, input logic [31:0] jv,
                       input logic [3:0] kt, input logic [31:0] kv);
    clear_in();
    in_valid = 1; in_op = op; in_dest = d; in_imm = imm; in_pc = pc;
    rj_tag = jt; rj_val = jv; rk_tag = kt; rk_val = kv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        op     dest  rjt   rjv       rjr rjrv      rkt   rkv       rkr rkrv      lsbd  lsbv      rssd  rssv      eqj   evj       eqk   evk
    vecs[0] = '{6'd3,  4'd5, 4'd0, 32'h10,   0, 32'h0,   4'd0, 32'h20,   0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h10,   4'd0, 32'h20};
    vecs[1] = '{6'd7,  4'd1, 4'd3, 32'hEE,   1, 32'h33,  4'd4, 32'hEE,   0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h33,   4'd4, 32'h0};
    vecs[2] = '{6'd9,  4'd2, 4'd6, 32'hEE,   0, 32'h0,   4'd6, 32'hEE,   0, 32'h0,   4'd6, 32'h66,  4'd6, 32'h77,  4'd0, 32'h66,   4'd0, 32'h66};
    vecs[3] = '{6'd12, 4'd3, 4'd8, 32'hEE,   1, 32'h11,  4'd9, 32'hEE,   1, 32'h99,  4'd0, 32'h0,   4'd8, 32'h88,  4'd0, 32'h88,   4'd0, 32'h99};
    vecs[4] = '{6'd20, 4'd4, 4'd0, 32'hAAAA, 0, 32'h0,   4'd2, 32'hEE,   0, 32'h0,   4'd2, 32'h22,  4'd0, 32'h0,   4'd0, 32'hAAAA, 4'd0, 32'h22};
    vecs[5] = '{6'd63, 4'd6, 4'd15,32'h5,    0, 32'h0,   4'd15,32'h6,    0, 32'h0,   4'd0, 32'h0,   4'd0, 32'h0,   4'd15,32'h0,    4'd15,32'h0};

    rst = 0; rdy = 1; reset_from_rob_bus = 0; is_rs_station_full = 0;
    clear_in();
    samp();
    chk("rst_dest", 64'(dest_to_rs), 64'd0);
    chk("rst_qj",   64'(qj_to_rs),   64'd0);
    chk("rst_vj",   64'(vj_to_rs),   64'd0);
    chk("rst_vk",   64'(vk_to_rs),   64'd0);
    next(); rst = 1;
    samp();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Table: one instruction each, buses only active at accept.
    for (int i = 0; i < 6; i++) begin
      next();
      offer(vecs[i].op, vecs[i].dest, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i),
            vecs[i].rj_tag, vecs[i].rj_val, vecs[i].rk_tag, vecs[i].rk_val);
      rj_rob_rdy = vecs[i].rj_rr; rj_rob_val = vecs[i].rj_rv;
      rk_rob_rdy = vecs[i].rk_rr; rk_rob_val = vecs[i].rk_rv;
      dest_from_lsb_bus = vecs[i].lsb_d; value_from_lsb_bus = vecs[i].lsb_v;
      dest_from_rss_bus = vecs[i].rss_d; value_from_rss_bus = vecs[i].rss_v;
      samp();
      chk("vec_in_ready", 64'(in_ready), 64'd1);
      push_exp(vecs[i].dest, vecs[i].op, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i),
               vecs[i].eqj, vecs[i].evj, vecs[i].eqk, vecs[i].evk);
      next(); clear_in();
      samp();
      chk("vec_disp_cycle", 64'(dest_to_rs), 64'(vecs[i].dest));
      next();
      samp();
      chk("vec_after_disp", 64'(dest_to_rs), 64'd0);
    end

    // RS full for 4 cycles, rss broadcast for the pending rj in the middle.
    next(); is_rs_station_full = 1;
    offer(6'd5, 4'd6, 32'h200, 32'h2000, 4'd7, 32'h0, 4'd0, 32'h2);
    samp(); chk("full_accept_ready", 64'(in_ready), 64'd1);
    push_exp(4'd6, 6'd5, 32'h200, 32'h2000, 4'd0, 32'hAB, 4'd0, 32'h2);
    next(); clear_in();
    samp(); chk("full_c1_dest", 64'(dest_to_rs), 64'd0); chk("full_c1_ready", 64'(in_ready), 64'd0);
    next(); dest_from_rss_bus = 4'd7; value_from_rss_bus = 32'hAB;
    samp(); chk("full_c2_dest", 64'(dest_to_rs), 64'd0);
    next(); clear_in();
    samp(); chk("full_c3_dest", 64'(dest_to_rs), 64'd0);
    next();
    samp(); chk("full_c4_dest", 64'(dest_to_rs), 64'd0);
    next(); is_rs_station_full = 0;
    samp(); chk("full_release_dest", 64'(dest_to_rs), 64'd6);
    next();
    samp(); chk("full_after_dest", 64'(dest_to_rs), 64'd0);

    // Full drops in the same cycle lsb broadcasts the pending rk (lsb beats rss).
    next(); is_rs_station_full = 1;
    offer(6'd8, 4'd3, 32'h300, 32'h3000, 4'd0, 32'h1, 4'd9, 32'h0);
    samp(); push_exp(4'd3, 6'd8, 32'h300, 32'h3000, 4'd0, 32'h1, 4'd0, 32'h55);
    next(); clear_in();
    samp(); chk("fwd_hold_dest", 64'(dest_to_rs), 64'd0);
    next(); is_rs_station_full = 0;
    dest_from_lsb_bus = 4'd9; value_from_lsb_bus = 32'h55;
    dest_from_rss_bus = 4'd9; value_from_rss_bus = 32'h77;
    samp(); chk("fwd_fire_dest", 64'(dest_to_rs), 64'd3);
    next(); clear_in();
    samp(); chk("fwd_after_dest", 64'(dest_to_rs), 64'd0);

    // Back-to-back stream 1,2,3.
    for (int i = 1; i <= 3; i++) begin
      next();
      offer(6'(10 + i), 4'(i), 32'(i), 32'(16 * i), 4'd0, 32'(i * 3), 4'd0, 32'(i * 5));
      samp();
      chk("stream_ready", 64'(in_ready), 64'd1);
      push_exp(4'(i), 6'(10 + i), 32'(i), 32'(16 * i), 4'd0, 32'(i * 3), 4'd0, 32'(i * 5));
      if (i > 1) chk("stream_dest", 64'(dest_to_rs), 64'(i - 1));
    end
    next(); clear_in();
    samp(); chk("stream_last_dest", 64'(dest_to_rs), 64'd3);
    next();
    samp(); chk("stream_idle_dest", 64'(dest_to_rs), 64'd0);

    // Flush while holding; a concurrent offer must be refused.
    next(); offer(6'd1, 4'd4, 32'h400, 32'h4000, 4'd0, 32'h0, 4'd0, 32'h0);
    samp();
    next(); reset_from_rob_bus = 1;
    offer(6'd2, 4'd11, 32'h0, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0);
    samp(); chk("flush_dest", 64'(dest_to_rs), 64'd0); chk("flush_ready", 64'(in_ready), 64'd0);
    next(); reset_from_rob_bus = 0; clear_in();
    samp(); chk("flush_after_dest", 64'(dest_to_rs), 64'd0); chk("flush_empty_ready", 64'(in_ready), 64'd1);

    // Async reset while holding with the RS about to free up.
    next(); is_rs_station_full = 1;
    offer(6'd4, 4'd12, 32'h500, 32'h5000, 4'd0, 32'h9, 4'd0, 32'h9);
    samp();
    next(); clear_in();
    samp(); chk("arst_hold_dest", 64'(dest_to_rs), 64'd0);
    next(); is_rs_station_full = 0; rst = 0;
    samp(); chk("arst_dest", 64'(dest_to_rs), 64'd0); chk("arst_vj", 64'(vj_to_rs), 64'd0);
    next(); rst = 1;
    samp(); chk("arst_after_dest", 64'(dest_to_rs), 64'd0); chk("arst_after_ready", 64'(in_ready), 64'd1);

    // rdy low freezes a held entry for one cycle.
    next(); offer(6'd6, 4'd13, 32'h600, 32'h6000, 4'd0, 32'h7, 4'd0, 32'h8);
    samp(); push_exp(4'd13, 6'd6, 32'h600, 32'h6000, 4'd0, 32'h7, 4'd0, 32'h8);
    next(); clear_in(); rdy = 0;
    samp(); chk("rdy0_dest", 64'(dest_to_rs), 64'd0); chk("rdy0_ready", 64'(in_ready), 64'd0);
    next(); rdy = 1;
    samp(); chk("rdy1_dest", 64'(dest_to_rs), 64'd13);
    next();
    samp(); chk("rdy1_after_dest", 64'(dest_to_rs), 64'd0);

`ifdef RS_DISPATCH_STATS_EN
    // Fresh counters: 5 stall cycles, then 3 dispatches.
    next(); rst = 0;
    next(); rst = 1;
    samp(); chk("stat_rst_disp", 64'(stat_dispatched), 64'd0);
    next(); is_rs_station_full = 1;
    offer(6'd1, 4'd1, 32'h0, 32'h0, 4'd0, 32'h1, 4'd0, 32'h1);
    samp(); push_exp(4'd1, 6'd1, 32'h0, 32'h0, 4'd0, 32'h1, 4'd0, 32'h1);
    next(); clear_in();
    for (int i = 0; i < 4; i++) next();
    next(); is_rs_station_full = 0;
    offer(6'd2, 4'd2, 32'h0, 32'h0, 4'd0, 32'h2, 4'd0, 32'h2);
    samp(); push_exp(4'd2, 6'd2, 32'h0, 32'h0, 4'd0, 32'h2, 4'd0, 32'h2);
    next(); offer(6'd3, 4'd3, 32'h0, 32'h0, 4'd0, 32'h3, 4'd0, 32'h3);
    samp(); push_exp(4'd3, 6'd3, 32'h0, 32'h0, 4'd0, 32'h3, 4'd0, 32'h3);
    next(); clear_in();
    samp();
    next();
    samp();
    chk("stat_dispatched", 64'(stat_dispatched), 64'd3);
    chk("stat_stall", 64'(stat_stall), 64'd5);
`endif

    next();
    samp();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
